// File: rtl/d_mem_rsp.sv
// d_mem_rsp
// Responder end of the core's data-memory interface. Holds the data RAM,
// lines byte/half/word lanes up with the address offset, and returns load
// data in the same cycle. For debug it also keeps sticky misalign and range
// error flags, captures the address of the first error, and keeps saturating
// load and store counters.
//
// Ports
//   Clk          in   1      clock, all state updates on the rising edge
//   Rst          in   1      synchronous active-high reset (RAM is not reset)
//   DMemAddress  in   32     byte address of the access
//   DMemData     in   32     store data, right-aligned
//   DMemByteEn   in   4      0001 byte, 0011 half, 1111 word
//   DMemWrEn     in   1      store request, committed at the rising edge
//   DMemRdEn     in   1      load request, answered combinationally
//   DMemRspData  out  32     load data, right-aligned, zero-extended
//   ErrClr       in   1      clears error flags and ErrAddr
//   MisalignErr  out  1      sticky misaligned / illegal ByteEn seen
//   RangeErr     out  1      sticky out-of-window access seen
//   ErrAddr      out  32     address of the first error since reset/clear
//   RdCnt        out  CNT_W  accepted loads, saturating
//   WrCnt        out  CNT_W  accepted stores, saturating
module d_mem_rsp #(
  parameter logic [31:0] D_MEM_BASE  = 32'h0000_1000,
  parameter int unsigned D_MEM_WORDS = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [31:0]      DMemAddress,
  input  logic [31:0]      DMemData,
  input  logic [3:0]       DMemByteEn,
  input  logic             DMemWrEn,
  input  logic             DMemRdEn,
  output logic [31:0]      DMemRspData,
  input  logic             ErrClr,
  output logic             MisalignErr,
  output logic             RangeErr,
  output logic [31:0]      ErrAddr,
  output logic [CNT_W-1:0] RdCnt,
  output logic [CNT_W-1:0] WrCnt
);

  localparam int unsigned AW        = $clog2(D_MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(D_MEM_WORDS * 4);

  logic [31:0] mem [D_MEM_WORDS];

  logic [31:0]    off;
  logic [AW-1:0]  idx;
  logic [1:0]     lane;
  logic           inRange;
  logic           aligned;
  logic           valid;
  logic           access;
  logic           newMisalign;
  logic           newRange;
  logic [3:0]     laneEn;
  logic [31:0]    wrData;
  logic [31:0]    rdWord;
  logic [31:0]    rdMask;
  logic           unusedOffBits;

  logic             misalignErrQ, misalignErrD;
  logic             rangeErrQ, rangeErrD;
  logic [31:0]      errAddrQ, errAddrD;
  logic [CNT_W-1:0] rdCntQ, rdCntD;
  logic [CNT_W-1:0] wrCntQ, wrCntD;

  assign off           = DMemAddress - D_MEM_BASE;
  assign idx           = off[AW+1:2];
  assign lane          = DMemAddress[1:0];
  assign unusedOffBits = ^{off[31:AW+2], off[1:0]};

  // The lower-bound test is needed separately because addresses below the
  // base wrap to huge offsets only by accident of the subtraction.
  assign inRange = (DMemAddress >= D_MEM_BASE) && (off < WIN_BYTES);

  // Illegal ByteEn codes are reported as misaligned.
  always_comb begin
    aligned = 1'b0;
    case (DMemByteEn)
      4'b0001: aligned = 1'b1;
      4'b0011: aligned = ~DMemAddress[0];
      4'b1111: aligned = (DMemAddress[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign valid       = inRange && aligned;
  assign access      = DMemWrEn || DMemRdEn;
  assign newRange    = access && !inRange;
  assign newMisalign = access && inRange && !aligned;

  assign laneEn = DMemByteEn << lane;
  assign wrData = DMemData << {lane, 3'b000};

  // The load path reads the RAM before this edge's store lands, so a
  // simultaneous read and write returns the old contents.
  assign rdWord      = mem[idx];
  assign rdMask      = {{8{DMemByteEn[3]}}, {8{DMemByteEn[2]}},
                        {8{DMemByteEn[1]}}, {8{DMemByteEn[0]}}};
  assign DMemRspData = (DMemRdEn && valid) ? ((rdWord >> {lane, 3'b000}) & rdMask) : 32'h0;

  // RAM write port; deliberately outside the reset so that a store
  // coinciding with Rst is still committed.
  always_ff @(posedge Clk) begin
    if (DMemWrEn && valid) begin
      for (int i = 0; i < 4; i++) begin
        if (laneEn[i]) begin
          mem[idx][8*i +: 8] <= wrData[8*i +: 8];
        end
      end
    end
  end

  // Error bookkeeping: a new error beats ErrClr in the same cycle, and
  // ErrAddr is only reloaded when no error is currently being held.
  always_comb begin
    misalignErrD = misalignErrQ;
    rangeErrD    = rangeErrQ;
    errAddrD     = errAddrQ;
    if (ErrClr) begin
      misalignErrD = 1'b0;
      rangeErrD    = 1'b0;
      errAddrD     = 32'h0;
    end
    if (newMisalign || newRange) begin
      if (newMisalign) misalignErrD = 1'b1;
      if (newRange)    rangeErrD    = 1'b1;
      if (ErrClr || (!misalignErrQ && !rangeErrQ)) begin
        errAddrD = DMemAddress;
      end
    end
  end

  always_comb begin
    rdCntD = rdCntQ;
    wrCntD = wrCntQ;
    if (DMemRdEn && valid && (rdCntQ != {CNT_W{1'b1}})) rdCntD = rdCntQ + 1'b1;
    if (DMemWrEn && valid && (wrCntQ != {CNT_W{1'b1}})) wrCntD = wrCntQ + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      misalignErrQ <= 1'b0;
      rangeErrQ    <= 1'b0;
      errAddrQ     <= 32'h0;
      rdCntQ       <= '0;
      wrCntQ       <= '0;
    end else begin
      misalignErrQ <= misalignErrD;
      rangeErrQ    <= rangeErrD;
      errAddrQ     <= errAddrD;
      rdCntQ       <= rdCntD;
      wrCntQ       <= wrCntD;
    end
  end

  assign MisalignErr = misalignErrQ;
  assign RangeErr    = rangeErrQ;
  assign ErrAddr     = errAddrQ;
  assign RdCnt       = rdCntQ;
  assign WrCnt       = wrCntQ;

endmodule

// File: tb/tb_d_mem_rsp.sv
// tb_d_mem_rsp
// Drives d_mem_rsp with directed and randomized accesses and compares every
// output against a byte-addressed reference model of the memory window.
module tb_d_mem_rsp;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;
  localparam int          CNTW  = 4;
  localparam int          WIN   = WORDS * 4;
  localparam int          CMAX  = (1 << CNTW) - 1;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic [31:0]     DMemAddress = '0;
  logic [31:0]     DMemData = '0;
  logic [3:0]      DMemByteEn = '0;
  logic            DMemWrEn = 1'b0;
  logic            DMemRdEn = 1'b0;
  logic [31:0]     DMemRspData;
  logic            ErrClr = 1'b0;
  logic            MisalignErr;
  logic            RangeErr;
  logic [31:0]     ErrAddr;
  logic [CNTW-1:0] RdCnt;
  logic [CNTW-1:0] WrCnt;

  d_mem_rsp #(
    .D_MEM_BASE (BASE),
    .D_MEM_WORDS(WORDS),
    .CNT_W      (CNTW)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .DMemAddress(DMemAddress),
    .DMemData   (DMemData),
    .DMemByteEn (DMemByteEn),
    .DMemWrEn   (DMemWrEn),
    .DMemRdEn   (DMemRdEn),
    .DMemRspData(DMemRspData),
    .ErrClr     (ErrClr),
    .MisalignErr(MisalignErr),
    .RangeErr   (RangeErr),
    .ErrAddr    (ErrAddr),
    .RdCnt      (RdCnt),
    .WrCnt      (WrCnt)
  );

  always #5 Clk = ~Clk;

  // Reference model: the RAM as a flat byte array plus the debug state.
  logic [7:0]  mMem [WIN];
  bit          mMis;
  bit          mRng;
  logic [31:0] mEa;
  int          mRd;
  int          mWr;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int accSize(input logic [3:0] be);
    case (be)
      4'b0001: return 1;
      4'b0011: return 2;
      4'b1111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit inWin(input logic [31:0] addr);
    return (addr >= BASE) && ((addr - BASE) < 32'(WIN));
  endfunction

  function automatic bit isAligned(input logic [31:0] addr, input logic [3:0] be);
    int sz;
    sz = accSize(be);
    if (sz == 0) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  // One access cycle: drive at the falling edge, check the combinational
  // response before the rising edge, update the model at the edge, then
  // check registered state just after it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be, input bit wr, input bit rd,
                               input bit clr, input bit rst);
    bit          vld;
    bit          inR;
    bit          al;
    int          sz;
    int          off;
    logic [31:0] expRsp;
    @(negedge Clk);
    DMemAddress = addr;
    DMemData    = data;
    DMemByteEn  = be;
    DMemWrEn    = wr;
    DMemRdEn    = rd;
    ErrClr      = clr;
    Rst         = rst;
    #1;
    inR    = inWin(addr);
    al     = isAligned(addr, be);
    vld    = inR && al;
    sz     = accSize(be);
    off    = int'(addr - BASE);
    expRsp = 32'h0;
    if (rd && vld) begin
      for (int k = 0; k < sz; k++) expRsp[8*k +: 8] = mMem[off + k];
    end
    checkOutput("rspData", DMemRspData, expRsp);
    @(posedge Clk);
    if (wr && vld) begin
      for (int k = 0; k < sz; k++) mMem[off + k] = data[8*k +: 8];
    end
    if (rst) begin
      mMis = 0;
      mRng = 0;
      mEa  = 32'h0;
      mRd  = 0;
      mWr  = 0;
    end else begin
      bit holding;
      bit errNow;
      holding = mMis || mRng;
      errNow  = (wr || rd) && !vld;
      if (clr) begin
        mMis = 0;
        mRng = 0;
        mEa  = 32'h0;
      end
      if (errNow) begin
        if (!inR) mRng = 1;
        else      mMis = 1;
        if (clr || !holding) mEa = addr;
      end
      if (rd && vld && mRd < CMAX) mRd++;
      if (wr && vld && mWr < CMAX) mWr++;
    end
    #1;
    checkOutput("misalignErr", 32'(MisalignErr), 32'(mMis));
    checkOutput("rangeErr", 32'(RangeErr), 32'(mRng));
    checkOutput("errAddr", ErrAddr, mEa);
    checkOutput("rdCnt", 32'(RdCnt), 32'(mRd));
    checkOutput("wrCnt", 32'(WrCnt), 32'(mWr));
  endtask

  task automatic randomAccess();
    logic [31:0] addr;
    logic [3:0]  be;
    int          sel;
    int          r;
    sel = int'($urandom_range(0, 9));
    r   = int'($urandom_range(0, 9));
    if (r < 3)      be = 4'b0001;
    else if (r < 6) be = 4'b0011;
    else if (r < 9) be = 4'b1111;
    else            be = 4'($urandom);
    if (sel < 7) begin
      addr = BASE + ($urandom % 32'(WIN));
      if ($urandom_range(0, 3) != 0 && accSize(be) != 0) begin
        addr = addr & ~(32'(accSize(be)) - 32'd1);
      end
    end else if (sel == 7) begin
      addr = BASE + 32'(WIN) + ($urandom % 32'd16);
    end else if (sel == 8) begin
      addr = BASE - 32'd1 - ($urandom % 32'd16);
    end else begin
      addr = $urandom;
    end
    applyStimulus(addr, $urandom, be, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 15) == 0), 1'b0);
  endtask

  initial begin
    mMis = 0;
    mRng = 0;
    mEa  = 32'h0;
    mRd  = 0;
    mWr  = 0;

    applyStimulus(32'h0, 32'h0, 4'b0000, 0, 0, 0, 1);

    // Word store and same-address word load.
    applyStimulus(BASE, 32'hDEAD_BEEF, 4'b1111, 1, 0, 0, 0);
    applyStimulus(BASE, 32'h0, 4'b1111, 0, 1, 0, 0);

    // Give every other word a known value before any further loads.
    for (int w = 1; w < WORDS; w++) begin
      applyStimulus(BASE + 32'(4 * w), $urandom, 4'b1111, 1, 0, 0, 0);
    end

    // Byte and half lanes.
    applyStimulus(BASE + 32'd3, 32'h0000_0012, 4'b0001, 1, 0, 0, 0);
    applyStimulus(BASE, 32'h0, 4'b1111, 0, 1, 0, 0);
    applyStimulus(BASE + 32'd3, 32'h0, 4'b0001, 0, 1, 0, 0);
    applyStimulus(BASE + 32'd2, 32'h0000_CAFE, 4'b0011, 1, 0, 0, 0);
    applyStimulus(BASE + 32'd2, 32'h0, 4'b0011, 0, 1, 0, 0);

    // Misaligned half, then an out-of-range load keeps the first ErrAddr.
    applyStimulus(BASE + 32'd1, 32'h0, 4'b0011, 0, 1, 0, 0);
    applyStimulus(BASE, 32'h0, 4'b1111, 0, 1, 0, 0);
    applyStimulus(BASE + 32'(WIN), 32'h0, 4'b1111, 0, 1, 0, 0);
    applyStimulus(BASE - 32'd4, 32'h0, 4'b1111, 0, 1, 0, 0);
    applyStimulus(32'h0, 32'h0, 4'b0000, 0, 0, 1, 0);

    // Top word of the window is valid; illegal ByteEn store is rejected.
    applyStimulus(BASE + 32'(WIN) - 32'd4, 32'h0, 4'b1111, 0, 1, 0, 0);
    applyStimulus(BASE + 32'd8, 32'hFFFF_FFFF, 4'b0101, 1, 0, 0, 0);
    applyStimulus(BASE + 32'd8, 32'h0, 4'b1111, 0, 1, 0, 0);

    // ErrClr together with a new out-of-range store: the new error wins.
    applyStimulus(BASE + 32'(WIN) + 32'd4, 32'h1234_5678, 4'b1111, 1, 0, 1, 0);

    // Read and write together return the old data.
    applyStimulus(BASE + 32'd12, 32'hA5A5_5A5A, 4'b1111, 1, 1, 0, 0);
    applyStimulus(BASE + 32'd12, 32'h0, 4'b1111, 0, 1, 0, 0);

    // Load counter saturation.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(BASE + 32'(4 * (n % WORDS)), 32'h0, 4'b1111, 0, 1, 0, 0);
    end

    for (int n = 0; n < 400; n++) randomAccess();

    // Reset with a coincident store: counters clear, the store lands.
    applyStimulus(BASE + 32'd16, 32'h0BAD_F00D, 4'b1111, 1, 0, 0, 1);
    applyStimulus(BASE + 32'd16, 32'h0, 4'b1111, 0, 1, 0, 0);
    applyStimulus(BASE + 32'd20, 32'h0, 4'b1111, 0, 1, 0, 0);

    for (int n = 0; n < 100; n++) randomAccess();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
